// File: rtl/psum_sched_pkg.sv
// Package for the partial-sum accumulator scheduler.
// Holds the default sizing and the scheduler state encoding shared by the top and its counter.
package psum_sched_pkg;

   localparam int NUM_BANKS_DEF = 16;
   localparam int SEL_W_DEF     = 4;
   localparam int PASS_W_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACCUM = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // A job is in flight in every state that walks the banks; DONE already reports idle.
   function automatic logic st_busy(input state_e st);
      logic res;
      case (st)
         ST_CLEAR: res = 1'b1;
         ST_ACCUM: res = 1'b1;
         ST_DRAIN: res = 1'b1;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/psum_idx_ctr.sv
// Nested bank/pass index counter for the accumulator scheduler.
// The bank index runs 0..bank_lim-1; on a bank wrap the pass index advances when pass_en is set.
// load restarts both indices at 0 and wins over inc. Limits are compared explicitly, never by natural wrap.
module psum_idx_ctr
#(
   parameter int SEL_W  = 4,
   parameter int PASS_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic              pass_en,
   input  logic [SEL_W:0]    bank_lim,
   input  logic [PASS_W-1:0] pass_lim,
   output logic [SEL_W-1:0]  bank_sel,
   output logic              last_bank,
   output logic              last_pass
);

   logic [SEL_W:0]    bank_r;
   logic [PASS_W-1:0] pass_r;

   assign last_bank = (bank_r == (bank_lim - (SEL_W+1)'(1)));
   assign last_pass = (pass_r == (pass_lim - PASS_W'(1)));
   assign bank_sel  = bank_r[SEL_W-1:0];

   // Bank/pass index registers: restart on load, step the bank and carry into the pass on wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_r <= '0;
         pass_r <= '0;
      end else if (load) begin
         bank_r <= '0;
         pass_r <= '0;
      end else if (inc) begin
         if (last_bank) begin
            bank_r <= '0;
            if (pass_en) begin
               pass_r <= pass_r + PASS_W'(1);
            end else begin
               pass_r <= pass_r;
            end
         end else begin
            bank_r <= bank_r + (SEL_W+1)'(1);
            pass_r <= pass_r;
         end
      end else begin
         bank_r <= bank_r;
         pass_r <= pass_r;
      end
   end

endmodule

// File: rtl/psum_acc_sched.sv
// Sequencer for the multi-bank partial-sum accumulator.
// A job clears cfg_banks banks, accumulates cfg_passes passes bank-by-bank (pass-major),
// then drains every bank, flagging each sum one cycle after its finish strobe.
// Optional build macro PSUM_SCHED_PERF_EN adds the stall_cnt output (ACCUM cycles without psum_valid).
module psum_acc_sched
   import psum_sched_pkg::*;
#(
   parameter int NUM_BANKS = NUM_BANKS_DEF,
   parameter int SEL_W     = SEL_W_DEF,
   parameter int PASS_W    = PASS_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEL_W:0]    cfg_banks,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic              psum_valid,
   output logic              psum_ready,
   output logic [SEL_W-1:0]  acc_sel,
   output logic              acc_clr,
   output logic              acc_zero_in,
   output logic              acc_finish,
   output logic              sum_valid,
   output logic [SEL_W-1:0]  sum_bank,
   output logic              busy,
   output logic              done
`ifdef PSUM_SCHED_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   state_e            state_r;
   state_e            state_s;
   logic [SEL_W:0]    banks_cfg_r;
   logic [PASS_W-1:0] passes_cfg_r;
   logic              cfg_latch_s;
   logic              ctr_load_s;
   logic              ctr_inc_s;
   logic              ctr_pass_en_s;
   logic [SEL_W-1:0]  bank_sel_s;
   logic              last_bank_s;
   logic              last_pass_s;
   logic              acc_clr_r;
   logic              acc_finish_r;
   logic              sum_valid_r;
   logic [SEL_W-1:0]  sum_bank_r;
   logic              busy_r;
   logic              done_r;

   psum_idx_ctr #(
      .SEL_W  (SEL_W),
      .PASS_W (PASS_W)
   ) u_idx_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ctr_load_s),
      .inc       (ctr_inc_s),
      .pass_en   (ctr_pass_en_s),
      .bank_lim  (banks_cfg_r),
      .pass_lim  (passes_cfg_r),
      .bank_sel  (bank_sel_s),
      .last_bank (last_bank_s),
      .last_pass (last_pass_s)
   );

   // The accumulator adds every cycle, so anything but a real transfer must feed it zeros.
   assign psum_ready  = (state_r == ST_ACCUM);
   assign acc_zero_in = !(psum_ready && psum_valid);
   assign acc_sel     = bank_sel_s;
   assign acc_clr     = acc_clr_r;
   assign acc_finish  = acc_finish_r;
   assign sum_valid   = sum_valid_r;
   assign sum_bank    = sum_bank_r;
   assign busy        = busy_r;
   assign done        = done_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and counter control; every walk restarts the bank index at 0 on its way out.
   always_comb begin
      state_s       = state_r;
      cfg_latch_s   = 1'b0;
      ctr_load_s    = 1'b0;
      ctr_inc_s     = 1'b0;
      ctr_pass_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               cfg_latch_s = 1'b1;
               ctr_load_s  = 1'b1;
               state_s     = ST_CLEAR;
            end else begin
               state_s     = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            ctr_inc_s = 1'b1;
            if (last_bank_s) begin
               ctr_load_s = 1'b1;
               if (passes_cfg_r == PASS_W'(0)) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_ACCUM;
               end
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_ACCUM: begin
            ctr_pass_en_s = 1'b1;
            ctr_inc_s     = psum_valid;
            if (psum_valid && last_bank_s && last_pass_s) begin
               ctr_load_s = 1'b1;
               state_s    = ST_DRAIN;
            end else begin
               state_s    = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            ctr_inc_s = 1'b1;
            if (last_bank_s) begin
               ctr_load_s = 1'b1;
               state_s    = ST_DONE;
            end else begin
               state_s    = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Job configuration captured on an accepted start; out-of-range bank counts mean all banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         banks_cfg_r  <= '0;
         passes_cfg_r <= '0;
      end else if (cfg_latch_s) begin
         if ((cfg_banks == (SEL_W+1)'(0)) || (cfg_banks > (SEL_W+1)'(NUM_BANKS))) begin
            banks_cfg_r <= (SEL_W+1)'(NUM_BANKS);
         end else begin
            banks_cfg_r <= cfg_banks;
         end
         passes_cfg_r <= cfg_passes;
      end else begin
         banks_cfg_r  <= banks_cfg_r;
         passes_cfg_r <= passes_cfg_r;
      end
   end

   // Output strobes follow the state being entered so they align with the bank index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_clr_r    <= 1'b0;
         acc_finish_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         sum_valid_r  <= 1'b0;
         sum_bank_r   <= '0;
      end else begin
         acc_clr_r    <= (state_s == ST_CLEAR);
         acc_finish_r <= (state_s == ST_DRAIN);
         busy_r       <= st_busy(state_s);
         done_r       <= (state_s == ST_DONE);
         if (state_r == ST_DRAIN) begin
            sum_valid_r <= 1'b1;
            sum_bank_r  <= bank_sel_s;
         end else begin
            sum_valid_r <= 1'b0;
            sum_bank_r  <= sum_bank_r;
         end
      end
   end

`ifdef PSUM_SCHED_PERF_EN
   logic [31:0] stall_cnt_r;

   assign stall_cnt = stall_cnt_r;

   // Saturating count of ACCUM cycles starved of psum_valid; restarts on each accepted job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
      end else if (cfg_latch_s) begin
         stall_cnt_r <= 32'd0;
      end else if (psum_ready && !psum_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end
`endif

endmodule
